// File: rtl/lcd_seq_pkg.sv
// lcd_seq_pkg: FSM state codes, init ROM, RS encodings and the long-instruction predicate shared by the LCD sequencer
package lcd_seq_pkg;
  typedef logic [2:0] state_t;
  localparam state_t ST_PWRUP = 3'd0;
  localparam state_t ST_INIT  = 3'd1;
  localparam state_t ST_IDLE  = 3'd2;
  localparam state_t ST_SETUP = 3'd3;
  localparam state_t ST_EHIGH = 3'd4;
  localparam state_t ST_HOLD  = 3'd5;
  localparam state_t ST_WAIT  = 3'd6;
  localparam logic RS_INSTR = 1'b0;
  localparam logic RS_DATA  = 1'b1;
  localparam int INIT_LEN = 6;
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
  function automatic logic is_long(input logic rs, input logic [7:0] data);
    return rs != RS_DATA && data[7:2] == 6'd0;
  endfunction
endpackage

// File: rtl/lcd_access_sequencer_if.sv
// lcd_access_sequencer_if: h/s requester handshakes (valid, rs, data, ready), init_done and LCD pins; slave = sequencer, master = environment
interface lcd_access_sequencer_if;
  logic       h_valid, h_rs, h_ready;
  logic [7:0] h_data;
  logic       s_valid, s_rs, s_ready;
  logic [7:0] s_data;
  logic       init_done;
  logic       lcd_RS, lcd_RW, lcd_E, lcd_data_oe;
  logic [7:0] lcd_data_out;
  modport slave (
    input  h_valid, h_rs, h_data, s_valid, s_rs, s_data,
    output h_ready, s_ready, init_done, lcd_RS, lcd_RW, lcd_E, lcd_data_out, lcd_data_oe
  );
  modport master (
    output h_valid, h_rs, h_data, s_valid, s_rs, s_data,
    input  h_ready, s_ready, init_done, lcd_RS, lcd_RW, lcd_E, lcd_data_out, lcd_data_oe
  );
endinterface

// File: rtl/lcd_delay_counter.sv
// lcd_delay_counter: down-counter; load/load_val reload it, done is high while the count is zero
module lcd_delay_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign done = cnt_q == '0;
  always_comb cnt_d = load ? load_val : (done ? cnt_q : cnt_q - CNT_W'(1));
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/lcd_access_sequencer.sv
// lcd_access_sequencer: HD44780 write sequencer; clk_clk/reset_reset_n plus bus (h/s valid-ready byte ports, init_done, lcd_RS/RW/E/data_out/data_oe)
module lcd_access_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned E_HIGH_CYC  = 12,
  parameter int unsigned HOLD_CYC    = 2,
  parameter int unsigned EXEC_CYC    = 2000,
  parameter int unsigned CLEAR_CYC   = 82000,
  parameter int unsigned POWERUP_CYC = 2000000,
  parameter int unsigned CNT_W       = 32
) (
  input logic                   clk_clk,
  input logic                   reset_reset_n,
  lcd_access_sequencer_if.slave bus
);
  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             armed_q, armed_d;
  logic             init_done_q, init_done_d;
  logic             ready_q, ready_d;
  logic             e_q, e_d;
  logic             oe_q, oe_d;
  logic             ld, done;
  logic [CNT_W-1:0] ld_val;
  lcd_delay_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .load          (ld),
    .load_val      (ld_val),
    .done          (done)
  );
  // Power-up needs one cycle to arm the counter because the counter resets to zero.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rs_d        = rs_q;
    data_d      = data_q;
    armed_d     = armed_q;
    init_done_d = init_done_q;
    ld          = 1'b0;
    ld_val      = '0;
    case (state_q)
      ST_PWRUP: begin
        armed_d = 1'b1;
        ld      = !armed_q;
        ld_val  = CNT_W'(POWERUP_CYC - 1);
        state_d = (armed_q && done) ? ST_INIT : ST_PWRUP;
      end
      ST_INIT: begin
        rs_d    = RS_INSTR;
        data_d  = INIT_ROM[idx_q];
        idx_d   = idx_q + 3'd1;
        ld      = 1'b1;
        ld_val  = CNT_W'(SETUP_CYC - 1);
        state_d = ST_SETUP;
      end
      ST_IDLE: begin
        if (ready_q && (bus.h_valid || bus.s_valid)) begin
          rs_d    = bus.h_valid ? bus.h_rs : bus.s_rs;
          data_d  = bus.h_valid ? bus.h_data : bus.s_data;
          ld      = 1'b1;
          ld_val  = CNT_W'(SETUP_CYC - 1);
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        ld      = done;
        ld_val  = CNT_W'(E_HIGH_CYC - 1);
        state_d = done ? ST_EHIGH : ST_SETUP;
      end
      ST_EHIGH: begin
        ld      = done;
        ld_val  = CNT_W'(HOLD_CYC - 1);
        state_d = done ? ST_HOLD : ST_EHIGH;
      end
      ST_HOLD: begin
        ld      = done;
        ld_val  = is_long(rs_q, data_q) ? CNT_W'(CLEAR_CYC - 1) : CNT_W'(EXEC_CYC - 1);
        state_d = done ? ST_WAIT : ST_HOLD;
      end
      ST_WAIT: begin
        if (done) begin
          init_done_d = init_done_q || idx_q == 3'(INIT_LEN);
          state_d     = init_done_d ? ST_IDLE : ST_INIT;
        end
      end
      default: state_d = ST_PWRUP;
    endcase
    e_d     = state_d == ST_EHIGH;
    oe_d    = state_d inside {ST_SETUP, ST_EHIGH, ST_HOLD};
    ready_d = state_d == ST_IDLE && init_done_d;
  end
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= ST_PWRUP;
      idx_q       <= '0;
      rs_q        <= 1'b0;
      data_q      <= '0;
      armed_q     <= 1'b0;
      init_done_q <= 1'b0;
      ready_q     <= 1'b0;
      e_q         <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      armed_q     <= armed_d;
      init_done_q <= init_done_d;
      ready_q     <= ready_d;
      e_q         <= e_d;
      oe_q        <= oe_d;
    end
  end
  assign bus.h_ready      = ready_q;
  assign bus.s_ready      = ready_q && !bus.h_valid;
  assign bus.init_done    = init_done_q;
  assign bus.lcd_RS       = rs_q;
  assign bus.lcd_RW       = 1'b0;
  assign bus.lcd_E        = e_q;
  assign bus.lcd_data_out = data_q;
  assign bus.lcd_data_oe  = oe_q;
endmodule

// File: tb/tb_lcd_access_sequencer.sv
// tb_lcd_access_sequencer: timeline model of the LCD sequencer checked every cycle, plus directed literal checks
module tb_lcd_access_sequencer;
  localparam int S = 2, EH = 4, HO = 2, EX = 10, CL = 50, PU = 20;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int checks = 0, passes = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  lcd_access_sequencer_if bus();
  lcd_access_sequencer #(
    .SETUP_CYC(S), .E_HIGH_CYC(EH), .HOLD_CYC(HO), .EXEC_CYC(EX),
    .CLEAR_CYC(CL), .POWERUP_CYC(PU), .CNT_W(32)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .bus           (bus)
  );
  logic [7:0] rom [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  // Model: each transaction starting at cycle t0 (accept or init-load cycle) drives
  // oe in t0+1..t0+S+EH+HO, E in t0+S+1..t0+S+EH, and frees the port at t0+S+EH+HO+wait+1.
  bit m_done = 0, tx_v = 0, in_rst = 1, prev_e = 0;
  logic tx_rs = 0;
  logic [7:0] tx_d = 0;
  int tx_s = 0, free_at = 0, idx = 0, rise_k = 0;
  logic [8:0] sb_q[$];
  int rise_q[$], wid_q[$];
  function automatic void start_tx(input logic rs, input logic [7:0] d);
    tx_v = 1;
    tx_rs = rs;
    tx_d = d;
    tx_s = cyc;
    free_at = cyc + S + EH + HO + ((!rs && d < 8'd4) ? CL : EX) + 1;
  endfunction
  always @(negedge clk) begin
    logic [14:0] exp_v, act_v;
    logic rdy;
    int rel;
    if (!rst_n) begin
      m_done = 0; tx_v = 0; tx_rs = 0; tx_d = 0; idx = 0; in_rst = 1; prev_e = 0;
    end else if (in_rst) begin
      in_rst = 0;
      free_at = cyc + 1 + PU;
    end
    if (rst_n && !m_done && idx == 6 && cyc == free_at) m_done = 1;
    rel = cyc - tx_s;
    rdy = m_done && cyc >= free_at;
    exp_v = {rdy, rdy && !bus.h_valid, m_done, tx_rs, 1'b0,
             tx_v && rel >= S + 1 && rel <= S + EH,
             tx_v && rel >= 1 && rel <= S + EH + HO, tx_d};
    act_v = {bus.h_ready, bus.s_ready, bus.init_done, bus.lcd_RS, bus.lcd_RW,
             bus.lcd_E, bus.lcd_data_oe, bus.lcd_data_out};
    chk("cycle_outputs", act_v, exp_v);
    if (rst_n) begin
      if (!m_done && idx < 6 && cyc == free_at) begin
        start_tx(1'b0, rom[idx]);
        idx++;
      end else if (rdy && (bus.h_valid || bus.s_valid))
        start_tx(bus.h_valid ? bus.h_rs : bus.s_rs, bus.h_valid ? bus.h_data : bus.s_data);
      if (bus.lcd_E && !prev_e) rise_k = cyc;
      if (!bus.lcd_E && prev_e) begin
        sb_q.push_back({bus.lcd_RS, bus.lcd_data_out});
        rise_q.push_back(rise_k);
        wid_q.push_back(cyc - rise_k);
      end
      prev_e = bus.lcd_E;
    end
  end
  task automatic wait_ready(input string name);
    int n = 0;
    @(negedge clk);
    while (!bus.h_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!bus.h_ready) begin
      checks++;
      $display("FAIL %s: ready not seen within 500 cycles", name);
    end
  endtask
  task automatic send_s(input logic rs, input logic [7:0] d, output int acc, output int lat);
    @(posedge clk); #2;
    bus.s_valid = 1; bus.s_rs = rs; bus.s_data = d;
    acc = -1;
    lat = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.s_ready) begin
        acc = cyc;
        break;
      end
    end
    @(posedge clk); #2;
    bus.s_valid = 0;
    if (acc < 0) return;
    @(negedge clk);
    chk("s_ready_drop", bus.s_ready, 0);
    for (int i = 0; i < 300; i++) begin
      if (bus.s_ready) begin
        lat = cyc - acc;
        break;
      end
      @(negedge clk);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end
  initial begin
    int rel, acc, lat, ha, sa, n;
    bus.h_valid = 0; bus.h_rs = 0; bus.h_data = 0;
    bus.s_valid = 1; bus.s_rs = 1; bus.s_data = 8'h55;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {bus.lcd_E, bus.lcd_data_oe, bus.init_done, bus.s_ready}, 0);
    #1;
    rst_n = 1;
    rel = cyc;
    acc = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.s_ready) begin
        acc = cyc;
        break;
      end
    end
    chk("preinit_accept_cycle", acc, rel + 175);
    chk("preinit_init_done", bus.init_done, 1);
    @(posedge clk); #2;
    bus.s_valid = 0;
    wait_ready("after_preinit");
    chk("init_strobe_count", sb_q.size(), 7);
    for (int i = 0; i < 6 && i < sb_q.size(); i++) begin
      chk("init_byte", sb_q[i], {1'b0, rom[i]});
      chk("init_e_width", wid_q[i], 4);
      if (i < 5) chk("init_rise_gap", rise_q[i + 1] - rise_q[i], (i == 4) ? 59 : 19);
    end
    if (sb_q.size() >= 7) chk("preinit_byte", sb_q[6], 9'h155);
    send_s(1'b1, 8'h41, acc, lat);
    chk("single_latency", lat, 19);
    chk("single_byte", sb_q[$], 9'h141);
    chk("single_e_rise", rise_q[$] - acc, 3);
    chk("single_e_width", wid_q[$], 4);
    @(posedge clk); #2;
    bus.h_valid = 1; bus.h_rs = 1; bus.h_data = 8'h80;
    bus.s_valid = 1; bus.s_rs = 1; bus.s_data = 8'h50;
    ha = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.h_ready) begin
        ha = cyc;
        break;
      end
    end
    chk("contention_s_stall", bus.s_ready, 0);
    @(posedge clk); #2;
    bus.h_valid = 0;
    sa = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.s_ready) begin
        sa = cyc;
        break;
      end
    end
    chk("contention_s_after_h", sa - ha, 19);
    @(posedge clk); #2;
    bus.s_valid = 0;
    wait_ready("after_contention");
    chk("contention_first", sb_q[$ - 1], 9'h180);
    chk("contention_second", sb_q[$], 9'h150);
    send_s(1'b0, 8'h01, acc, lat);
    chk("clear_latency", lat, 59);
    send_s(1'b0, 8'h02, acc, lat);
    chk("home_latency", lat, 59);
    send_s(1'b0, 8'h03, acc, lat);
    chk("home3_latency", lat, 59);
    send_s(1'b0, 8'h04, acc, lat);
    chk("instr04_latency", lat, 19);
    send_s(1'b0, 8'h0C, acc, lat);
    chk("display_on_latency", lat, 19);
    send_s(1'b1, 8'h01, acc, lat);
    chk("data01_latency", lat, 19);
    @(posedge clk); #2;
    bus.s_valid = 1; bus.s_rs = 1; bus.s_data = 8'h41;
    @(posedge clk); #2;
    bus.s_valid = 0;
    for (int i = 0; i < 20 && !bus.lcd_E; i++) begin
      @(posedge clk); #2;
    end
    chk("midstrobe_e_seen", bus.lcd_E, 1);
    n = sb_q.size();
    rst_n = 0;
    #1;
    chk("async_reset_e", bus.lcd_E, 0);
    chk("async_reset_oe", bus.lcd_data_oe, 0);
    chk("async_reset_init_done", bus.init_done, 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1;
    wait_ready("after_reinit");
    chk("reinit_strobe_count", sb_q.size() - n, 6);
    for (int i = 0; i < 6 && n + i < sb_q.size(); i++) chk("reinit_byte", sb_q[n + i], {1'b0, rom[i]});
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
